// File: rtl/mmc1_cpu_bus_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mmc1_cpu_bus_if                                             |
// | Purpose  : CPU-bus front end for the MMC1 mapper core. Oversamples the |
// |            asynchronous NES CPU bus, qualifies one write per CPU cycle,|
// |            drops the second write of back-to-back (RMW) pairs, and     |
// |            emits single-cycle strobes to the serial shift stage.       |
// | Ports    : ck, res (async, active-high)                                |
// |            m2, romsel_n, rw, cpu_d0, cpu_d7, cpu_a13, cpu_a14 : bus in |
// |            cyc_stb  : one pulse per valid CPU cycle                    |
// |            wr_stb   : qualified serial load write                      |
// |            wr_rst   : qualified write with D7=1 (shift reset)          |
// |            wr_d0/wr_reg : data/register index, held until next wr_stb |
// |            bus_err  : sticky M2 timeout flag                           |
// | Options  : define MMC1_BUS_TIMEOUT_EN to enable the M2-high timeout;   |
// |            otherwise bus_err is tied 0.                                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mmc1_cpu_bus_if #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_HIGH      = 3,
  parameter int CONSEC_FILTER = 1
) (
  input  logic       ck,
  input  logic       res,
  input  logic       m2,
  input  logic       romsel_n,
  input  logic       rw,
  input  logic       cpu_d0,
  input  logic       cpu_d7,
  input  logic       cpu_a13,
  input  logic       cpu_a14,
  output logic       cyc_stb,
  output logic       wr_stb,
  output logic       wr_rst,
  output logic       wr_d0,
  output logic [1:0] wr_reg,
  output logic       bus_err
);

  // Bus vector: {vld, m2, romsel_n, rw, d7, d0, a14, a13}.
  // The vld bit is a constant 1 shifted through the chain; it marks the point
  // after reset where the synced bus reflects real pins instead of reset values.
  localparam logic [7:0] c_sync_rst = 8'b0011_0000;
  localparam logic [5:0] c_cap_rst  = 6'b11_0000;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_HIGH   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] w_bus_in;
  logic [7:0] w_s;

  assign w_bus_in = {1'b1, m2, romsel_n, rw, cpu_d7, cpu_d0, cpu_a14, cpu_a13};

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge ck or posedge res) begin
        if (res) r_sync[gi] <= c_sync_rst;
        else     r_sync[gi] <= w_bus_in;
      end
    end else begin : g_next
      always_ff @(posedge ck or posedge res) begin
        if (res) r_sync[gi] <= c_sync_rst;
        else     r_sync[gi] <= r_sync[gi-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [5:0] r_cap, w_cap_nxt;        // {romsel_n, rw, d7, d0, a14, a13}
  logic       r_prev_wr, w_prev_nxt;
  logic       r_armed, w_armed_nxt;    // a genuine low phase has been seen
  logic       w_cyc_nxt, w_stb_nxt, w_rst_nxt, w_d0_nxt;
  logic [1:0] w_reg_nxt;
  logic       w_rom_wr;

`ifdef MMC1_BUS_TIMEOUT_EN
  logic [7:0] r_to, w_to_nxt;
  logic       r_err, w_err_nxt;
  assign bus_err = r_err;
`else
  assign bus_err = 1'b0;
`endif

  assign w_rom_wr = ~r_cap[5] & ~r_cap[4];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_prev_nxt  = r_prev_wr;
    // A phase already in progress at reset release must not be committed, so
    // HIGH is only entered after a real low level has propagated through.
    w_armed_nxt = r_armed | (w_s[7] & ~w_s[6]);
    w_cyc_nxt   = 1'b0;
    w_stb_nxt   = 1'b0;
    w_rst_nxt   = 1'b0;
    w_d0_nxt    = wr_d0;
    w_reg_nxt   = wr_reg;
`ifdef MMC1_BUS_TIMEOUT_EN
    w_to_nxt    = r_to;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      ST_LOW: begin
        if (r_armed && w_s[6]) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = 4'd1;
          w_cap_nxt   = w_s[5:0];
`ifdef MMC1_BUS_TIMEOUT_EN
          w_to_nxt    = 8'd0;
`endif
        end
      end
      ST_HIGH: begin
        if (w_s[6]) begin
          w_cnt_nxt = (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
          w_cap_nxt = w_s[5:0];
`ifdef MMC1_BUS_TIMEOUT_EN
          if (r_cnt == 4'd15) begin
            if (r_to == 8'd239) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_LOW;
              w_prev_nxt  = 1'b0;
              w_armed_nxt = 1'b0;
            end else begin
              w_to_nxt = r_to + 8'd1;
            end
          end
`endif
        end else if (r_cnt >= 4'(MIN_HIGH)) begin
          // Strobes are registered here so they are high during COMMIT.
          w_state_nxt = ST_COMMIT;
          w_cyc_nxt   = 1'b1;
          if (w_rom_wr && ((CONSEC_FILTER == 0) || !r_prev_wr)) begin
            if (r_cap[3]) begin
              w_rst_nxt = 1'b1;
            end else begin
              w_stb_nxt = 1'b1;
              w_d0_nxt  = r_cap[2];
              w_reg_nxt = r_cap[1:0];
            end
          end
          w_prev_nxt = w_rom_wr;
        end else begin
          w_state_nxt = ST_LOW;   // glitch: filter state untouched
        end
      end
      ST_COMMIT: w_state_nxt = ST_LOW;
      default:   w_state_nxt = ST_LOW;
    endcase
  end

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_state   <= ST_LOW;
      r_cnt     <= 4'd0;
      r_cap     <= c_cap_rst;
      r_prev_wr <= 1'b0;
      r_armed   <= 1'b0;
      cyc_stb   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_rst    <= 1'b0;
      wr_d0     <= 1'b0;
      wr_reg    <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cap     <= w_cap_nxt;
      r_prev_wr <= w_prev_nxt;
      r_armed   <= w_armed_nxt;
      cyc_stb   <= w_cyc_nxt;
      wr_stb    <= w_stb_nxt;
      wr_rst    <= w_rst_nxt;
      wr_d0     <= w_d0_nxt;
      wr_reg    <= w_reg_nxt;
    end
  end

`ifdef MMC1_BUS_TIMEOUT_EN
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_to  <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_to  <= w_to_nxt;
      r_err <= w_err_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmc1_cpu_bus_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mmc1_cpu_bus_if                                          |
// | Purpose  : Directed self-checking bench for mmc1_cpu_bus_if.           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_mmc1_cpu_bus_if;

  localparam int SYNC = 2;

  logic       ck = 1'b0;
  logic       res = 1'b1;
  logic       m2 = 1'b1, romsel_n = 1'b0, rw = 1'b0;
  logic       cpu_d0 = 1'b1, cpu_d7 = 1'b1, cpu_a13 = 1'b1, cpu_a14 = 1'b1;
  logic       cyc_stb, wr_stb, wr_rst, wr_d0, bus_err;
  logic [1:0] wr_reg;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_count = 0;
  int n_cyc_p = 0, n_stb_p = 0, n_rst_p = 0, n_both_p = 0;
  int last_cyc_at = 0;
  int fall_cyc = 0;
  int s_cyc, s_stb, s_rst;

  mmc1_cpu_bus_if #(.SYNC_STAGES(SYNC), .MIN_HIGH(3), .CONSEC_FILTER(1)) dut (
    .ck(ck), .res(res), .m2(m2), .romsel_n(romsel_n), .rw(rw),
    .cpu_d0(cpu_d0), .cpu_d7(cpu_d7), .cpu_a13(cpu_a13), .cpu_a14(cpu_a14),
    .cyc_stb(cyc_stb), .wr_stb(wr_stb), .wr_rst(wr_rst), .wr_d0(wr_d0),
    .wr_reg(wr_reg), .bus_err(bus_err)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc_count <= cyc_count + 1;

  always @(negedge ck) begin
    if (cyc_stb) begin
      n_cyc_p     <= n_cyc_p + 1;
      last_cyc_at <= cyc_count;
    end
    if (wr_stb) n_stb_p <= n_stb_p + 1;
    if (wr_rst) n_rst_p <= n_rst_p + 1;
    if (wr_stb && wr_rst) n_both_p <= n_both_p + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge ck);
    #2;
  endtask

  task automatic snap();
    s_cyc = n_cyc_p;
    s_stb = n_stb_p;
    s_rst = n_rst_p;
  endtask

  // One CPU cycle: M2 high for 'hi' clocks with the given bus, then 8 low clocks.
  task automatic bus_cycle(input bit rom, input bit rd, input logic [7:0] d,
                           input logic [1:0] regsel, input int hi);
    @(posedge ck); #2;
    romsel_n = ~rom; rw = rd; cpu_d0 = d[0]; cpu_d7 = d[7];
    cpu_a14 = regsel[1]; cpu_a13 = regsel[0]; m2 = 1'b1;
    repeat (hi) @(posedge ck);
    #2;
    m2 = 1'b0; romsel_n = 1'b1; rw = 1'b1;
    fall_cyc = cyc_count;
    idle(8);
  endtask

  task automatic test_reset();
    idle(3);
    n_chk++; if (cyc_stb !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb: got %b expected 0", cyc_stb); end
    n_chk++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stb: got %b expected 0", wr_stb); end
    n_chk++; if (wr_rst !== 1'b0) begin n_fail++; $display("FAIL reset_wr_rst: got %b expected 0", wr_rst); end
    n_chk++; if (wr_d0 !== 1'b0) begin n_fail++; $display("FAIL reset_wr_d0: got %b expected 0", wr_d0); end
    n_chk++; if (wr_reg !== 2'd0) begin n_fail++; $display("FAIL reset_wr_reg: got %0d expected 0", wr_reg); end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    m2 = 1'b0; romsel_n = 1'b1; rw = 1'b1; cpu_d0 = 1'b0; cpu_d7 = 1'b0; cpu_a13 = 1'b0; cpu_a14 = 1'b0;
    idle(1);
    res = 1'b0;
    idle(6);
  endtask

  task automatic test_serial_write();
    snap();
    bus_cycle(1'b1, 1'b0, 8'h01, 2'd0, 6);   // write $8000 = 0x01
    n_chk++; if (n_cyc_p - s_cyc !== 1) begin n_fail++; $display("FAIL w8000_cyc: got %0d expected 1", n_cyc_p - s_cyc); end
    n_chk++; if (n_stb_p - s_stb !== 1) begin n_fail++; $display("FAIL w8000_stb: got %0d expected 1", n_stb_p - s_stb); end
    n_chk++; if (n_rst_p - s_rst !== 0) begin n_fail++; $display("FAIL w8000_rst: got %0d expected 0", n_rst_p - s_rst); end
    n_chk++; if (wr_d0 !== 1'b1) begin n_fail++; $display("FAIL w8000_d0: got %b expected 1", wr_d0); end
    n_chk++; if (wr_reg !== 2'd0) begin n_fail++; $display("FAIL w8000_reg: got %0d expected 0", wr_reg); end
    n_chk++; if (last_cyc_at !== fall_cyc + SYNC + 1) begin n_fail++; $display("FAIL latency: got %0d expected %0d", last_cyc_at, fall_cyc + SYNC + 1); end
  endtask

  task automatic test_shift_reset();
    bus_cycle(1'b1, 1'b1, 8'h00, 2'd0, 6);   // read breaks the write run
    snap();
    bus_cycle(1'b1, 1'b0, 8'h80, 2'd3, 6);   // write $E000 = 0x80
    n_chk++; if (n_rst_p - s_rst !== 1) begin n_fail++; $display("FAIL wE000_rst: got %0d expected 1", n_rst_p - s_rst); end
    n_chk++; if (n_stb_p - s_stb !== 0) begin n_fail++; $display("FAIL wE000_stb: got %0d expected 0", n_stb_p - s_stb); end
    n_chk++; if (n_cyc_p - s_cyc !== 1) begin n_fail++; $display("FAIL wE000_cyc: got %0d expected 1", n_cyc_p - s_cyc); end
    n_chk++; if (wr_reg !== 2'd0) begin n_fail++; $display("FAIL wE000_reg_held: got %0d expected 0", wr_reg); end
    n_chk++; if (wr_d0 !== 1'b1) begin n_fail++; $display("FAIL wE000_d0_held: got %b expected 1", wr_d0); end
    n_chk++; if (n_both_p !== 0) begin n_fail++; $display("FAIL stb_rst_overlap: got %0d expected 0", n_both_p); end
  endtask

  task automatic test_back_to_back();
    bus_cycle(1'b1, 1'b1, 8'h00, 2'd0, 6);   // read clears the filter
    snap();
    bus_cycle(1'b1, 1'b0, 8'h00, 2'd1, 6);   // write $A000 = 0
    n_chk++; if (n_stb_p - s_stb !== 1) begin n_fail++; $display("FAIL rmw1_stb: got %0d expected 1", n_stb_p - s_stb); end
    n_chk++; if (wr_d0 !== 1'b0) begin n_fail++; $display("FAIL rmw1_d0: got %b expected 0", wr_d0); end
    n_chk++; if (wr_reg !== 2'd1) begin n_fail++; $display("FAIL rmw1_reg: got %0d expected 1", wr_reg); end
    snap();
    bus_cycle(1'b1, 1'b0, 8'h01, 2'd1, 6);   // write $A000 = 1, back-to-back
    n_chk++; if (n_cyc_p - s_cyc !== 1) begin n_fail++; $display("FAIL rmw2_cyc: got %0d expected 1", n_cyc_p - s_cyc); end
    n_chk++; if (n_stb_p - s_stb !== 0) begin n_fail++; $display("FAIL rmw2_stb: got %0d expected 0", n_stb_p - s_stb); end
    n_chk++; if (wr_d0 !== 1'b0) begin n_fail++; $display("FAIL rmw2_d0_held: got %b expected 0", wr_d0); end
    bus_cycle(1'b1, 1'b1, 8'h00, 2'd0, 6);
    snap();
    bus_cycle(1'b1, 1'b0, 8'h01, 2'd1, 6);
    n_chk++; if (n_stb_p - s_stb !== 1) begin n_fail++; $display("FAIL rmw3_stb: got %0d expected 1", n_stb_p - s_stb); end
    n_chk++; if (wr_d0 !== 1'b1) begin n_fail++; $display("FAIL rmw3_d0: got %b expected 1", wr_d0); end
  endtask

  task automatic test_glitch();
    bus_cycle(1'b1, 1'b1, 8'h00, 2'd0, 6);   // filter cleared
    snap();
    bus_cycle(1'b1, 1'b0, 8'h01, 2'd2, 2);   // 2-ck glitch write
    n_chk++; if (n_cyc_p - s_cyc !== 0) begin n_fail++; $display("FAIL glitch_cyc: got %0d expected 0", n_cyc_p - s_cyc); end
    n_chk++; if (n_stb_p - s_stb !== 0) begin n_fail++; $display("FAIL glitch_stb: got %0d expected 0", n_stb_p - s_stb); end
    snap();
    bus_cycle(1'b1, 1'b0, 8'h00, 2'd2, 3);   // exactly MIN_HIGH: valid, $C000 = 0
    n_chk++; if (n_stb_p - s_stb !== 1) begin n_fail++; $display("FAIL minhigh_stb: got %0d expected 1", n_stb_p - s_stb); end
    n_chk++; if (wr_reg !== 2'd2) begin n_fail++; $display("FAIL minhigh_reg: got %0d expected 2", wr_reg); end
    bus_cycle(1'b1, 1'b1, 8'h00, 2'd0, 2);   // glitch read must not clear filter
    snap();
    bus_cycle(1'b1, 1'b0, 8'h01, 2'd3, 6);
    n_chk++; if (n_stb_p - s_stb !== 0) begin n_fail++; $display("FAIL glitch_keeps_filter: got %0d expected 0", n_stb_p - s_stb); end
    n_chk++; if (wr_reg !== 2'd2) begin n_fail++; $display("FAIL glitch_reg_held: got %0d expected 2", wr_reg); end
  endtask

  task automatic test_non_rom();
    snap();
    bus_cycle(1'b1, 1'b1, 8'h01, 2'd2, 6);   // read $C000
    bus_cycle(1'b0, 1'b0, 8'h01, 2'd3, 6);   // write $6000 (romsel_n=1)
    n_chk++; if (n_cyc_p - s_cyc !== 2) begin n_fail++; $display("FAIL nonrom_cyc: got %0d expected 2", n_cyc_p - s_cyc); end
    n_chk++; if (n_stb_p - s_stb !== 0) begin n_fail++; $display("FAIL nonrom_stb: got %0d expected 0", n_stb_p - s_stb); end
    n_chk++; if (n_rst_p - s_rst !== 0) begin n_fail++; $display("FAIL nonrom_rst: got %0d expected 0", n_rst_p - s_rst); end
    snap();
    bus_cycle(1'b1, 1'b0, 8'h01, 2'd2, 6);   // $6000 write cleared the filter
    n_chk++; if (n_stb_p - s_stb !== 1) begin n_fail++; $display("FAIL after_nonrom_stb: got %0d expected 1", n_stb_p - s_stb); end
  endtask

  task automatic test_reset_mid();
    snap();
    @(posedge ck); #2;
    romsel_n = 1'b0; rw = 1'b0; cpu_d0 = 1'b1; cpu_d7 = 1'b0; cpu_a14 = 1'b0; cpu_a13 = 1'b1; m2 = 1'b1;
    idle(3);
    res = 1'b1;
    #1;
    n_chk++; if (wr_d0 !== 1'b0) begin n_fail++; $display("FAIL resmid_d0: got %b expected 0", wr_d0); end
    n_chk++; if (wr_reg !== 2'd0) begin n_fail++; $display("FAIL resmid_reg: got %0d expected 0", wr_reg); end
    #3;
    res = 1'b0;
    idle(6);
    m2 = 1'b0; romsel_n = 1'b1; rw = 1'b1;
    idle(8);
    n_chk++; if (n_cyc_p - s_cyc !== 0) begin n_fail++; $display("FAIL resmid_cyc: got %0d expected 0", n_cyc_p - s_cyc); end
    n_chk++; if (n_stb_p - s_stb !== 0) begin n_fail++; $display("FAIL resmid_stb: got %0d expected 0", n_stb_p - s_stb); end
    snap();
    bus_cycle(1'b1, 1'b0, 8'h01, 2'd3, 6);
    n_chk++; if (n_stb_p - s_stb !== 1) begin n_fail++; $display("FAIL post_reset_stb: got %0d expected 1", n_stb_p - s_stb); end
    n_chk++; if (wr_reg !== 2'd3) begin n_fail++; $display("FAIL post_reset_reg: got %0d expected 3", wr_reg); end
  endtask

  task automatic test_timeout();
    bus_cycle(1'b1, 1'b1, 8'h00, 2'd0, 6);   // filter cleared
    snap();
    bus_cycle(1'b1, 1'b0, 8'h00, 2'd1, 300); // M2 stuck high during a ROM write
`ifdef MMC1_BUS_TIMEOUT_EN
    n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", bus_err); end
    n_chk++; if (n_cyc_p - s_cyc !== 0) begin n_fail++; $display("FAIL timeout_cyc: got %0d expected 0", n_cyc_p - s_cyc); end
    n_chk++; if (n_stb_p - s_stb !== 0) begin n_fail++; $display("FAIL timeout_stb: got %0d expected 0", n_stb_p - s_stb); end
`else
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL notimeout_err: got %b expected 0", bus_err); end
    n_chk++; if (n_cyc_p - s_cyc !== 1) begin n_fail++; $display("FAIL notimeout_cyc: got %0d expected 1", n_cyc_p - s_cyc); end
    n_chk++; if (n_stb_p - s_stb !== 1) begin n_fail++; $display("FAIL notimeout_stb: got %0d expected 1", n_stb_p - s_stb); end
`endif
  endtask

  initial begin
    test_reset();
    test_serial_write();
    test_shift_reset();
    test_back_to_back();
    test_glitch();
    test_non_rom();
    test_reset_mid();
    test_timeout();
    n_chk++; if (n_both_p !== 0) begin n_fail++; $display("FAIL final_overlap: got %0d expected 0", n_both_p); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmc1_cpu_bus_if.md
Name: mmc1_cpu_bus_if

Overview:
- Synchronous CPU-bus front end for the MMC1 mapper core, in single-clock FPGA builds.
- Oversamples the asynchronous NES CPU bus signals (M2, /ROMSEL, R/W, D0, D7, A13, A14) on the system clock.
- Qualifies one write per CPU cycle and drops the second write of back-to-back (RMW) pairs.
- Delivers single-cycle write strobes (serial bit, shift reset, register index) to the mapper's serial shift/register stage directly downstream.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on every bus input; legal 2..4.
- MIN_HIGH, 3: minimum consecutive ck cycles of synced M2 high before a phase counts as a valid CPU cycle; legal 1..15.
- CONSEC_FILTER, 1: 1 = drop a ROM write whose immediately preceding valid CPU cycle was also a ROM write; 0 = pass all ROM writes.

Ports:
- ck  in  1  system clock; must be ≥ 8x M2 frequency.
- res  in  1  asynchronous reset, active-high.
- m2  in  1  CPU M2 phase, asynchronous.
- romsel_n  in  1  /ROMSEL, asynchronous.
- rw  in  1  CPU R/W; 1 = read.
- cpu_d0  in  1  data bit 0.
- cpu_d7  in  1  data bit 7.
- cpu_a13  in  1  address bit 13.
- cpu_a14  in  1  address bit 14.
- cyc_stb  out  1  one-cycle pulse per valid CPU cycle, at M2 fall.
- wr_stb  out  1  one-cycle pulse: qualified serial load write.
- wr_rst  out  1  one-cycle pulse: write with D7=1 (shift reset).
- wr_d0  out  1  D0 of the qualified write; held until next strobe.
- wr_reg  out  2  {A14,A13} of the qualified write; held until next strobe.
- bus_err  out  1  sticky M2 timeout flag (feature only; else tied 0).

Behaviour:
- Reset (async, res=1): all outputs 0; FSM = LOW; high counter = 0; prev_wr = 0; synchronizer chains cleared to m2=0, romsel_n=1, rw=1, data/address 0.
- Sync: all inputs pass through SYNC_STAGES flops, so bus fields stay phase-aligned with m2. A one-stage capture register (cap_*) holds the synced bus.
- FSM LOW: wait for synced m2=1, then go to HIGH with cnt=1.
- FSM HIGH: while m2=1, cnt increments, saturating at 15, and cap_* loads every ck, so the last sample before the fall is the one used.
  - m2 falls with cnt < MIN_HIGH: glitch; return to LOW, no pulses, prev_wr unchanged.
  - m2 falls with cnt ≥ MIN_HIGH: go to COMMIT.
- FSM COMMIT (one ck): cyc_stb=1. Evaluate rom_wr = (cap_romsel_n==0 && cap_rw==0).
  - rom_wr=1 and (CONSEC_FILTER==0 or prev_wr==0):
    - cap_d7=1: wr_rst=1.
    - else: wr_stb=1, wr_d0=cap_d0, wr_reg={cap_a14,cap_a13}.
  - prev_wr <= rom_wr, updated even when the write was filtered.
  - Next state: LOW.
- wr_stb and wr_rst are mutually exclusive; each is exactly 1 ck wide.
- Latency: pulses appear SYNC_STAGES+1 ck after the raw M2 falling edge.
- The consecutive filter resets only on a non-ROM-write valid cycle; glitches do not clear it.
- res asserted mid-phase: everything clears immediately. After release, if m2 is already high, the FSM waits in LOW for a full fall and rise, so the partial phase yields no pulse.
- Outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro MMC1_BUS_TIMEOUT_EN.
- Defined: in HIGH, when cnt saturates and m2 stays high for a further 240 ck (256-ck total budget, 8-bit counter):
  - bus_err is set (sticky until res);
  - FSM returns to LOW with no pulses;
  - prev_wr is cleared.
- Undefined: no timeout counter; HIGH waits indefinitely; bus_err tied 0.

Test Plan:
- Write $8000 with D=0x01, M2 high 6 ck → one wr_stb, wr_d0=1, wr_reg=0, wr_rst=0, cyc_stb=1, at fall+SYNC_STAGES+1.
- Write $E000 with D=0x80 → wr_rst=1, wr_stb=0, wr_reg unchanged from the previous value.
- RMW pair: write $A000 D=0x00 then write $A000 D=0x01 on the next cycle → first gives wr_stb with wr_d0=0, second gives cyc_stb only. A third write after one read cycle → wr_stb, wr_d0=1.
- M2 glitch high for 2 ck with MIN_HIGH=3 during a ROM write → no cyc_stb, no wr_stb; prev_wr unchanged.
- Read $C000 (rw=1), and a write with romsel_n=1 ($6000) → cyc_stb only; no write pulses.
- res pulsed mid-M2-high during a write → outputs 0 at once, no pulse for that phase. With MMC1_BUS_TIMEOUT_EN, M2 held high for 300 ck → bus_err=1, no strobes.
